// File: rtl/alu_exec_pkg.sv
`default_nettype none
// ============================================================================
// Module   : alu_exec_pkg
// Brief    : ALU op codes shared with the ALU control decoder, plus the
//            execution-unit state encoding.
// Revision : 1.0 - initial release
// ============================================================================
package alu_exec_pkg;

    localparam logic [3:0] ALU_AND     = 4'b0000;
    localparam logic [3:0] ALU_OR      = 4'b0001;
    localparam logic [3:0] ALU_NOR     = 4'b0010;
    localparam logic [3:0] ALU_ADD     = 4'b0011;
    localparam logic [3:0] ALU_SLL     = 4'b0100;
    localparam logic [3:0] ALU_SRL     = 4'b0101;
    localparam logic [3:0] ALU_LUI     = 4'b1000;
    localparam logic [3:0] ALU_SUB     = 4'b1001;
    localparam logic [3:0] ALU_ILLEGAL = 4'b1111;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    function automatic logic is_shift_op(input logic [3:0] op);
        return (op == ALU_SLL) || (op == ALU_SRL);
    endfunction

endpackage
`default_nettype wire

// File: rtl/alu_exec_comb.sv
`default_nettype none
// ============================================================================
// Module   : alu_exec_comb
// Brief    : Single-cycle ALU datapath (logic, add/sub, lui, illegal detect).
//            Optional signed-overflow flag under ALU_EXEC_OVERFLOW_EN.
// Revision : 1.0 - initial release
// ============================================================================
module alu_exec_comb
    import alu_exec_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic [3:0]       i_op,
    input  logic [WIDTH-1:0] i_a,
    input  logic [WIDTH-1:0] i_b,
    output logic [WIDTH-1:0] o_result,
    output logic             o_illegal,
    output logic             o_shift
`ifdef ALU_EXEC_OVERFLOW_EN
   ,output logic             o_overflow
`endif
);

    localparam int c_msb  = WIDTH - 1;
    localparam int c_half = WIDTH / 2;

    logic [WIDTH-1:0] w_sum;
    logic [WIDTH-1:0] w_diff;

    assign w_sum  = i_a + i_b;
    assign w_diff = i_a - i_b;

    always_comb begin
        o_result  = '0;
        o_illegal = 1'b0;
        o_shift   = 1'b0;
        case (i_op)
            ALU_AND: o_result = i_a & i_b;
            ALU_OR:  o_result = i_a | i_b;
            ALU_NOR: o_result = ~(i_a | i_b);
            ALU_ADD: o_result = w_sum;
            ALU_SUB: o_result = w_diff;
            ALU_LUI: o_result = {i_b[c_half-1:0], {c_half{1'b0}}};
            // Shifts are iterated by the top level; the datapath only flags them.
            ALU_SLL, ALU_SRL: o_shift = 1'b1;
            default: o_illegal = 1'b1;
        endcase
    end

`ifdef ALU_EXEC_OVERFLOW_EN
    assign o_overflow =
        ((i_op == ALU_ADD) && (i_a[c_msb] == i_b[c_msb]) && (w_sum[c_msb]  != i_a[c_msb])) ||
        ((i_op == ALU_SUB) && (i_a[c_msb] != i_b[c_msb]) && (w_diff[c_msb] != i_a[c_msb]));
`endif

endmodule
`default_nettype wire

// File: rtl/alu_exec_unit.sv
`default_nettype none
// ============================================================================
// Module   : alu_exec_unit
// Brief    : EX-stage ALU with valid/ready handshake; single-cycle ops plus
//            bit-serial SLL/SRL. Define ALU_EXEC_OVERFLOW_EN for the overflow port.
// Revision : 1.0 - initial release
// ============================================================================
module alu_exec_unit
    import alu_exec_pkg::*;
#(
    parameter int WIDTH   = 32,
    parameter int SHAMT_W = 5
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [3:0]         alu_operation,
    input  logic [WIDTH-1:0]   op_a,
    input  logic [WIDTH-1:0]   op_b,
    input  logic [SHAMT_W-1:0] shamt,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [WIDTH-1:0]   result,
    output logic               zero,
    output logic               illegal_op,
    output logic               busy
`ifdef ALU_EXEC_OVERFLOW_EN
   ,output logic               overflow
`endif
);

    state_t             r_state;
    logic [WIDTH-1:0]   r_work;
    logic [SHAMT_W-1:0] r_cnt;
    logic               r_left;
    logic [WIDTH-1:0]   r_result;
    logic               r_zero;
    logic               r_illegal;

    logic [WIDTH-1:0]   w_comb_result;
    logic               w_comb_illegal;
    logic               w_comb_shift;

`ifdef ALU_EXEC_OVERFLOW_EN
    logic               r_overflow;
    logic               w_comb_overflow;
`endif

    alu_exec_comb #(
        .WIDTH (WIDTH)
    ) u_comb (
        .i_op       (alu_operation),
        .i_a        (op_a),
        .i_b        (op_b),
        .o_result   (w_comb_result),
        .o_illegal  (w_comb_illegal),
        .o_shift    (w_comb_shift)
`ifdef ALU_EXEC_OVERFLOW_EN
       ,.o_overflow (w_comb_overflow)
`endif
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state   <= IDLE;
            r_work    <= '0;
            r_cnt     <= '0;
            r_left    <= 1'b0;
            r_result  <= '0;
            r_zero    <= 1'b0;
            r_illegal <= 1'b0;
`ifdef ALU_EXEC_OVERFLOW_EN
            r_overflow <= 1'b0;
`endif
        end else begin
            case (r_state)
                IDLE: begin
                    if (in_valid) begin
                        if (w_comb_shift) begin
                            r_work  <= op_b;
                            r_cnt   <= shamt;
                            r_left  <= (alu_operation == ALU_SLL);
                            r_state <= SHIFT;
                        end else begin
                            r_result  <= w_comb_result;
                            r_zero    <= (w_comb_result == '0);
                            r_illegal <= w_comb_illegal;
`ifdef ALU_EXEC_OVERFLOW_EN
                            r_overflow <= w_comb_overflow;
`endif
                            r_state   <= DONE;
                        end
                    end
                end
                SHIFT: begin
                    // One extra cycle at cnt==0 moves the finished word into the result.
                    if (r_cnt == '0) begin
                        r_result  <= r_work;
                        r_zero    <= (r_work == '0);
                        r_illegal <= 1'b0;
`ifdef ALU_EXEC_OVERFLOW_EN
                        r_overflow <= 1'b0;
`endif
                        r_state   <= DONE;
                    end else begin
                        r_work <= r_left ? (r_work << 1) : (r_work >> 1);
                        r_cnt  <= r_cnt - SHAMT_W'(1);
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        r_state <= IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign in_ready   = (r_state == IDLE);
    assign out_valid  = (r_state == DONE);
    assign busy       = (r_state == SHIFT) || (r_state == DONE);
    assign result     = r_result;
    assign zero       = r_zero;
    assign illegal_op = r_illegal;
`ifdef ALU_EXEC_OVERFLOW_EN
    assign overflow   = r_overflow;
`endif

endmodule
`default_nettype wire

// File: tb/tb_alu_exec_unit.sv
`default_nettype none
// ============================================================================
// Module   : tb_alu_exec_unit
// Brief    : Scoreboard bench for alu_exec_unit: directed corner cases plus
//            random ops against an arithmetic reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_alu_exec_unit;

    logic        clk = 1'b0;
    logic        reset;
    logic        in_valid;
    logic        in_ready;
    logic [3:0]  alu_operation;
    logic [31:0] op_a;
    logic [31:0] op_b;
    logic [4:0]  shamt;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] result;
    logic        zero;
    logic        illegal_op;
    logic        busy;
`ifdef ALU_EXEC_OVERFLOW_EN
    logic        overflow;
`endif

    alu_exec_unit #(
        .WIDTH   (32),
        .SHAMT_W (5)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .in_valid      (in_valid),
        .in_ready      (in_ready),
        .alu_operation (alu_operation),
        .op_a          (op_a),
        .op_b          (op_b),
        .shamt         (shamt),
        .out_valid     (out_valid),
        .out_ready     (out_ready),
        .result        (result),
        .zero          (zero),
        .illegal_op    (illegal_op),
        .busy          (busy)
`ifdef ALU_EXEC_OVERFLOW_EN
       ,.overflow      (overflow)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] res;
        logic        z;
        logic        ill;
        logic        ovf;
        int          lat;
        int          acc;
    } exp_t;

    exp_t sb[$];
    int   total = 0;
    int   bad   = 0;
    int   cyc   = 0;
    int   rdy_mode = 2;   // 0 random, 1 hold low, 2 hold high
    logic        seen = 1'b0;
    logic [31:0] held;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input longint act, input longint exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Reference model: results from plain arithmetic on signed/unsigned values.
    function automatic exp_t model(input logic [3:0] op, input logic [31:0] a,
                                   input logic [31:0] b, input logic [4:0] sh);
        exp_t   e;
        longint sa, sbv, s;
        sa  = longint'($signed(a));
        sbv = longint'($signed(b));
        e.res = 32'h0; e.ill = 1'b0; e.ovf = 1'b0; e.lat = 1; e.acc = 0;
        case (op)
            4'd0: e.res = a & b;
            4'd1: e.res = a | b;
            4'd2: e.res = ~(a | b);
            4'd3: begin
                s = sa + sbv; e.res = 32'(s);
                e.ovf = (s > 64'sd2147483647) || (s < -64'sd2147483648);
            end
            4'd9: begin
                s = sa - sbv; e.res = 32'(s);
                e.ovf = (s > 64'sd2147483647) || (s < -64'sd2147483648);
            end
            4'd4: begin e.res = b << sh; e.lat = int'(sh) + 2; end
            4'd5: begin e.res = b >> sh; e.lat = int'(sh) + 2; end
            4'd8: e.res = b * 32'h0001_0000;
            default: e.ill = 1'b1;
        endcase
        e.z = (e.res == 32'h0);
        return e;
    endfunction

    // Drive one request at a negedge; returns the cycle stamp of the accept.
    task automatic drive(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                         input logic [4:0] sh, output int acc);
        int guard = 0;
        while (!in_ready && guard < 100) begin
            @(negedge clk);
            guard++;
        end
        if (!in_ready) begin
            $display("FAIL in_ready_timeout: got 0 expected 1");
            bad++;
            $display("test done: total=%0d bad=%0d", total, bad);
            $fatal(1, "in_ready never returned");
        end
        alu_operation = op; op_a = a; op_b = b; shamt = sh; in_valid = 1'b1;
        acc = cyc;
        @(negedge clk);
        in_valid = 1'b0;
        alu_operation = 4'($urandom); op_a = $urandom; op_b = $urandom; shamt = 5'($urandom);
    endtask

    task automatic issue(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                         input logic [4:0] sh);
        exp_t e;
        int   acc;
        e = model(op, a, b, sh);
        sb.push_back(e);
        drive(op, a, b, sh, acc);
        sb[sb.size()-1].acc = acc;
    endtask

    // out_ready is changed just after the active edge so it is stable at the monitor.
    initial begin
        out_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            case (rdy_mode)
                0:       out_ready = 1'($urandom);
                1:       out_ready = 1'b0;
                default: out_ready = 1'b1;
            endcase
        end
    end

    // Monitor: latency on first sight of out_valid, stability while stalled, data on handshake.
    always @(negedge clk) begin
        if (reset) begin
            seen = 1'b0;
        end else if (out_valid) begin
            check("busy_while_valid", busy, 1);
            check("in_ready_while_valid", in_ready, 0);
            if (!seen) begin
                seen = 1'b1;
                held = result;
                if (sb.size() == 0) begin
                    total++; bad++;
                    $display("FAIL unexpected_output: got result 0x%0h expected no output", result);
                end else begin
                    check("latency", cyc - sb[0].acc, sb[0].lat);
                end
            end else begin
                check("hold_stable", result, held);
            end
            if (out_ready) begin
                seen = 1'b0;
                if (sb.size() > 0) begin
                    exp_t e;
                    e = sb.pop_front();
                    check("result", result, e.res);
                    check("zero", zero, e.z);
                    check("illegal_op", illegal_op, e.ill);
`ifdef ALU_EXEC_OVERFLOW_EN
                    check("overflow", overflow, e.ovf);
`endif
                end
            end
        end
    end

    task automatic drain();
        int guard = 0;
        while (sb.size() > 0 && guard < 200) begin
            @(negedge clk);
            guard++;
        end
        check("drain_queue_empty", sb.size(), 0);
        @(negedge clk);
    endtask

    initial begin
        int acc;
        int vcount;
        logic [3:0] ops[10];
        ops = '{4'd0, 4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd8, 4'd9, 4'd15, 4'd6};
        reset = 1'b1; in_valid = 1'b0; alu_operation = 4'h0;
        op_a = 32'h0; op_b = 32'h0; shamt = 5'h0;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        check("rst_in_ready", in_ready, 1);
        check("rst_out_valid", out_valid, 0);
        check("rst_result", result, 0);
        check("rst_zero", zero, 0);
        check("rst_illegal", illegal_op, 0);
        check("rst_busy", busy, 0);
`ifdef ALU_EXEC_OVERFLOW_EN
        check("rst_overflow", overflow, 0);
`endif

        // Abort a long shift with reset; it must never produce a result.
        drive(4'd4, 32'h0, 32'h0000_0001, 5'd20, acc);
        repeat (4) @(negedge clk);
        check("busy_mid_shift", busy, 1);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check("abort_out_valid", out_valid, 0);
        check("abort_result", result, 0);
        check("abort_in_ready", in_ready, 1);
        vcount = 0;
        repeat (30) begin
            @(negedge clk);
            if (out_valid) vcount++;
        end
        check("abort_no_output", vcount, 0);

        issue(4'd3, 32'h0000_0005, 32'h0000_0003, 5'd0);
        issue(4'd9, 32'h1234_5678, 32'h1234_5678, 5'd0);
        issue(4'd9, 32'h8000_0000, 32'h0000_0001, 5'd0);
        issue(4'd3, 32'h7FFF_FFFF, 32'h0000_0001, 5'd0);
        issue(4'd4, 32'h0, 32'h0000_0001, 5'd31);
        issue(4'd5, 32'h0, 32'h8000_0000, 5'd0);
        issue(4'd5, 32'h0, 32'h8000_0000, 5'd31);
        issue(4'd8, 32'h0, 32'h0000_ABCD, 5'd0);
        issue(4'd15, 32'hDEAD_BEEF, 32'h1234_5678, 5'd0);
        drain();

        // Backpressure: result must hold while out_ready stays low.
        rdy_mode = 1;
        @(negedge clk);
        issue(4'd1, 32'h0000_00F0, 32'h0000_000F, 5'd3);
        repeat (4) begin
            check("bp_valid", out_valid, 1);
            check("bp_in_ready", in_ready, 0);
            check("bp_result", result, 32'hFF);
            @(negedge clk);
        end
        rdy_mode = 2;
        @(negedge clk);
        @(negedge clk);
        check("bp_release_valid", out_valid, 0);
        check("bp_release_in_ready", in_ready, 1);
        drain();

        rdy_mode = 0;
        repeat (150) begin
            logic [31:0] a, b;
            a = $urandom;
            b = $urandom;
            if ($urandom_range(0, 4) == 0) b = a;
            issue(ops[$urandom_range(0, 9)], a, b, 5'($urandom));
        end
        rdy_mode = 2;
        drain();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/alu_exec_unit.md
Name: alu_exec_unit

Overview:
- Execution-side consumer of the 4-bit ALU operation code produced by the ALU control decoder.
- Executes the decoded operation on two operands behind a valid/ready handshake and returns a registered result with flags.
- Logic ops, add, sub and lui complete in one cycle. Sll and srl are iterative, shifting one bit per cycle.
- Sits in the EX stage and lets the pipeline stall on long shifts.

Parameters:
- WIDTH, 32, operand/result width; must be even and >= 8.
- SHAMT_W, 5, shift-amount width; must equal clog2(WIDTH).

Ports:
- clk  input  1  rising-edge clock
- reset  input  1  synchronous, active-high reset
- in_valid  input  1  operation request
- in_ready  output  1  unit can accept a request (high only in IDLE)
- alu_operation  input  4  decoded op code
- op_a  input  WIDTH  operand A (rs)
- op_b  input  WIDTH  operand B (rt or immediate)
- shamt  input  SHAMT_W  shift amount
- out_valid  output  1  result available
- out_ready  input  1  consumer takes result
- result  output  WIDTH  registered result
- zero  output  1  result == 0
- illegal_op  output  1  op code not recognised
- busy  output  1  high in SHIFT or DONE

Behaviour:
- Clock and reset: one clock, clk. Reset is synchronous and active-high on reset.
  - On reset: state = IDLE; result = 0; zero = 0; illegal_op = 0; out_valid = 0; busy = 0; in_ready = 1 from the first cycle after reset.
- Op codes and results:
  - AND 0000: a & b.
  - OR 0001: a | b.
  - NOR 0010: ~(a | b).
  - ADD 0011: a + b, mod 2^WIDTH.
  - SLL 0100: b << shamt.
  - SRL 0101: b >> shamt, zero fill.
  - LUI 1000: {b[WIDTH/2-1:0], WIDTH/2 zeros}.
  - SUB 1001: a - b, mod 2^WIDTH.
  - Any other code, including 1111: result = 0, zero = 1, illegal_op = 1.
- Handshake:
  - Accept occurs when in_valid & in_ready. Inputs are sampled only at accept.
  - in_ready = (state == IDLE).
  - Outputs change only on the DONE-entry cycle. They hold stable while out_valid & !out_ready.
- State machine:
  - IDLE:
    - Accept of a non-shift op or an illegal op: result and flags are registered, go to DONE. out_valid rises 1 cycle after accept.
    - Accept of SLL/SRL: load work_reg = b and cnt = shamt, latch the direction, go to SHIFT.
  - SHIFT:
    - If cnt == 0: result = work_reg, go to DONE.
    - Else: shift work_reg by 1 in the latched direction, cnt = cnt - 1.
    - Shift latency from accept to out_valid is shamt + 2 cycles. shamt = 0 gives 2 cycles.
  - DONE: out_valid = 1. When out_ready is high, go to IDLE. out_valid drops the next cycle.
- Throughput: at most one op per 2 cycles. Accept and completion never occur in the same cycle.
- Boundaries:
  - shamt = WIDTH-1 gives WIDTH+1 cycles.
  - out_ready already high on DONE entry gives a 1-cycle out_valid pulse.
  - in_valid while busy is ignored; the requester must hold it.
  - Reset in SHIFT or DONE aborts the op without producing a result.
  - The zero flag is always computed from the registered result.

Optional Feature:
- Macro: ALU_EXEC_OVERFLOW_EN.
- When defined: adds output port overflow, 1 bit, registered with result.
  - Set on signed overflow of ADD: operand signs equal and result sign differs.
  - Set on signed overflow of SUB: operand signs differ and result sign differs from a.
  - 0 for all other ops and after reset.
- When undefined: the port and its logic are absent; all other behaviour is identical.

Decomposition:
- Package alu_exec_pkg:
  - localparams for the 4-bit op codes: ALU_AND, ALU_OR, ALU_NOR, ALU_ADD, ALU_SLL, ALU_SRL, ALU_LUI, ALU_SUB, ALU_ILLEGAL = 4'b1111.
  - State encoding: IDLE = 2'd0, SHIFT = 2'd1, DONE = 2'd2.
  - The same op-code constants are shared with the ALU control decoder.
- Sub-module alu_exec_comb: purely combinational single-cycle datapath (logic, add/sub, lui, illegal detect, optional overflow).
  - The top level holds the FSM, shift counter, work register and output registers.

Test Plan:
- Reset mid-SHIFT (shamt=20, reset at cycle 5) -> next cycle out_valid=0, result=0, in_ready=1; no result ever emitted.
- ADD a=0x00000005, b=0x00000003 -> out_valid 1 cycle after accept, result=0x00000008, zero=0.
- SUB a=0x12345678, b=0x12345678 -> result=0, zero=1. With the macro defined: SUB a=0x80000000, b=1 -> result=0x7FFFFFFF, overflow=1.
- SLL b=0x00000001, shamt=31 -> out_valid exactly 33 cycles after accept, result=0x80000000. SRL b=0x80000000, shamt=0 -> 2 cycles, result=0x80000000.
- LUI b=0x0000ABCD -> result=0xABCD0000. Op 1111 -> result=0, zero=1, illegal_op=1, latency 1.
- Backpressure: out_ready=0 for 4 cycles after OR a=0xF0, b=0x0F -> result=0xFF held stable, in_ready=0 throughout; out_ready=1 -> out_valid drops next cycle, in_ready=1.
